// File: rtl/xosera_bus_if.sv
// Host-bus front end: synchronizes the asynchronous 8-bit m68k-style bus into
// the pixel-clock domain, turns each decoded access into a single-cycle
// register strobe, assembles byte writes into 16-bit words and returns read
// data byte-wide to the pad driver.
module xosera_bus_if #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        bus_cs_n_i,
  input  logic        bus_rd_nwr_i,
  input  logic        bus_bytesel_i,
  input  logic [3:0]  bus_reg_num_i,
  input  logic [7:0]  bus_data_i,
  output logic [7:0]  bus_data_o,
  input  logic [15:0] reg_rd_word_i,
  output logic [3:0]  reg_num_o,
  output logic        reg_bytesel_o,
  output logic [15:0] reg_wr_word_o,
  output logic        reg_write_strobe_o,
  output logic        reg_read_strobe_o,
  output logic        bus_active_o
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACTIVE,
    RELEASE
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] cs_n_pipe;
  logic [SYNC_STAGES-1:0] rd_nwr_pipe;
  logic [SYNC_STAGES-1:0] bytesel_pipe;
  logic [3:0]             reg_num_pipe [SYNC_STAGES];
  logic [7:0]             data_pipe    [SYNC_STAGES];

  logic       cs_n_s;
  logic       rd_nwr_s;
  logic       bytesel_s;
  logic [3:0] reg_num_s;
  logic [7:0] data_s;

  state_t     state;
  logic [3:0] settle_cnt;
  logic       is_read;
  logic [7:0] hold_hi;

  assign cs_n_s    = cs_n_pipe[SYNC_STAGES-1];
  assign rd_nwr_s  = rd_nwr_pipe[SYNC_STAGES-1];
  assign bytesel_s = bytesel_pipe[SYNC_STAGES-1];
  assign reg_num_s = reg_num_pipe[SYNC_STAGES-1];
  assign data_s    = data_pipe[SYNC_STAGES-1];

  // Input synchronizers; select idles deasserted (high) out of reset.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cs_n_pipe    <= '1;
      rd_nwr_pipe  <= '0;
      bytesel_pipe <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        reg_num_pipe[i] <= '0;
        data_pipe[i]    <= '0;
      end
    end else begin
      cs_n_pipe       <= {cs_n_pipe[SYNC_STAGES-2:0], bus_cs_n_i};
      rd_nwr_pipe     <= {rd_nwr_pipe[SYNC_STAGES-2:0], bus_rd_nwr_i};
      bytesel_pipe    <= {bytesel_pipe[SYNC_STAGES-2:0], bus_bytesel_i};
      reg_num_pipe[0] <= bus_reg_num_i;
      data_pipe[0]    <= bus_data_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        reg_num_pipe[i] <= reg_num_pipe[i-1];
        data_pipe[i]    <= data_pipe[i-1];
      end
    end
  end

  // Access sequencer: settle, capture, strobe, then wait for select release.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state              <= IDLE;
      settle_cnt         <= '0;
      is_read            <= 1'b0;
      hold_hi            <= '0;
      reg_num_o          <= '0;
      reg_bytesel_o      <= 1'b0;
      reg_wr_word_o      <= '0;
      reg_write_strobe_o <= 1'b0;
      reg_read_strobe_o  <= 1'b0;
      bus_active_o       <= 1'b0;
    end else begin
      reg_write_strobe_o <= 1'b0;
      reg_read_strobe_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (!cs_n_s) begin
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (cs_n_s) begin
            state <= IDLE;
          end else if (settle_cnt == 4'd0) begin
            reg_num_o     <= reg_num_s;
            reg_bytesel_o <= bytesel_s;
            is_read       <= rd_nwr_s;
            bus_active_o  <= 1'b1;
            state         <= ACTIVE;
            if (!rd_nwr_s) begin
              if (bytesel_s) begin
                reg_wr_word_o      <= {hold_hi, data_s};
                reg_write_strobe_o <= 1'b1;
              end else begin
                hold_hi <= data_s;
              end
            end
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ACTIVE: begin
          if (!is_read) begin
            state <= RELEASE;
          end else if (cs_n_s) begin
            reg_read_strobe_o <= 1'b1;
            bus_active_o      <= 1'b0;
            state             <= IDLE;
          end
        end
        RELEASE: begin
          if (cs_n_s) begin
            bus_active_o <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read byte follows the register file every clock for the captured byte lane.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      bus_data_o <= '0;
    end else begin
      bus_data_o <= reg_bytesel_o ? reg_rd_word_i[7:0] : reg_rd_word_i[15:8];
    end
  end

endmodule

// File: tb/tb_xosera_bus_if.sv
// Self-checking bench for xosera_bus_if: a table of whole bus accesses plus
// hand-written sequences for reset, select glitches and read-data tracking.
module tb_xosera_bus_if;

  localparam int SS = 2;
  localparam int SC = 2;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        bus_cs_n_i;
  logic        bus_rd_nwr_i;
  logic        bus_bytesel_i;
  logic [3:0]  bus_reg_num_i;
  logic [7:0]  bus_data_i;
  logic [7:0]  bus_data_o;
  logic [15:0] reg_rd_word_i;
  logic [3:0]  reg_num_o;
  logic        reg_bytesel_o;
  logic [15:0] reg_wr_word_o;
  logic        reg_write_strobe_o;
  logic        reg_read_strobe_o;
  logic        bus_active_o;

  typedef struct {
    logic        rd;
    logic        bsel;
    logic [3:0]  rnum;
    logic [7:0]  dat;
    logic [15:0] rdWord;
    int          lowCycles;
    int          expWr;
    logic [15:0] expWord;
    int          expRd;
    logic [7:0]  expData;
  } vec_t;

  vec_t vecs [10];

  int testsRun = 0;
  int testsFailed = 0;
  int wrTotal = 0;
  int rdTotal = 0;
  int overlapCount = 0;

  xosera_bus_if #(
    .SYNC_STAGES  (SS),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk               (clk),
    .reset_n_i         (reset_n_i),
    .bus_cs_n_i        (bus_cs_n_i),
    .bus_rd_nwr_i      (bus_rd_nwr_i),
    .bus_bytesel_i     (bus_bytesel_i),
    .bus_reg_num_i     (bus_reg_num_i),
    .bus_data_i        (bus_data_i),
    .bus_data_o        (bus_data_o),
    .reg_rd_word_i     (reg_rd_word_i),
    .reg_num_o         (reg_num_o),
    .reg_bytesel_o     (reg_bytesel_o),
    .reg_wr_word_o     (reg_wr_word_o),
    .reg_write_strobe_o(reg_write_strobe_o),
    .reg_read_strobe_o (reg_read_strobe_o),
    .bus_active_o      (bus_active_o)
  );

  always #5 clk = ~clk;

  // Count strobes between rising edges so hand sequences can check deltas.
  always @(negedge clk) begin
    if (reg_write_strobe_o) wrTotal++;
    if (reg_read_strobe_o) rdTotal++;
    if (reg_write_strobe_o && reg_read_strobe_o) overlapCount++;
  end

  function automatic logic [31:0] allOutputs();
    return {bus_data_o, reg_num_o, reg_bytesel_o, reg_wr_word_o,
            reg_write_strobe_o, reg_read_strobe_o, bus_active_o};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    testsRun++;
    if (act < lo || act > hi) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic busIdle();
    bus_cs_n_i    = 1'b1;
    bus_rd_nwr_i  = 1'b1;
    bus_bytesel_i = 1'b0;
    bus_reg_num_i = 4'h0;
    bus_data_i    = 8'h00;
  endtask

  // One full access: select low for lowCycles clocks, then five clocks released.
  task automatic applyStimulus(input vec_t v,
                               output int wrCount, output int wrEdge,
                               output logic [15:0] wrWord, output logic [3:0] wrNum,
                               output int rdCount, output int rdEdge,
                               output logic [7:0] dataEnd, output logic activeEnd,
                               output int activeClear);
    wrCount = 0; wrEdge = -1; wrWord = '0; wrNum = '0;
    rdCount = 0; rdEdge = -1; activeClear = -1;
    reg_rd_word_i = v.rdWord;
    bus_rd_nwr_i  = v.rd;
    bus_bytesel_i = v.bsel;
    bus_reg_num_i = v.rnum;
    bus_data_i    = v.dat;
    bus_cs_n_i    = 1'b0;
    for (int n = 0; n < v.lowCycles; n++) begin
      @(posedge clk);
      #1;
      if (reg_write_strobe_o) begin
        wrCount++;
        wrEdge = n;
        wrWord = reg_wr_word_o;
        wrNum  = reg_num_o;
      end
      if (reg_read_strobe_o) rdCount++;
    end
    dataEnd   = bus_data_o;
    activeEnd = bus_active_o;
    busIdle();
    for (int m = 0; m < 5; m++) begin
      @(posedge clk);
      #1;
      if (reg_write_strobe_o) wrCount++;
      if (reg_read_strobe_o) begin
        rdCount++;
        rdEdge = m;
      end
      if (!bus_active_o && activeClear < 0) activeClear = m;
    end
  endtask

  initial begin
    int wrCount, wrEdge, rdCount, rdEdge, activeClear, base;
    logic [15:0] wrWord;
    logic [3:0]  wrNum;
    logic [7:0]  dataEnd;
    logic        activeEnd;
    logic [31:0] seen;
    vec_t        v;

    vecs[0] = '{1'b0, 1'b0, 4'h5, 8'h12, 16'h0000, 8,  0, 16'h0000, 0, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 4'h5, 8'h34, 16'h0000, 8,  1, 16'h1234, 0, 8'h00};
    vecs[2] = '{1'b1, 1'b1, 4'h3, 8'h00, 16'hBEEF, 8,  0, 16'h0000, 1, 8'hEF};
    vecs[3] = '{1'b1, 1'b0, 4'h3, 8'h00, 16'hBEEF, 8,  0, 16'h0000, 1, 8'hBE};
    vecs[4] = '{1'b0, 1'b0, 4'hA, 8'hA5, 16'h0000, 8,  0, 16'h0000, 0, 8'h00};
    vecs[5] = '{1'b0, 1'b1, 4'hA, 8'h5A, 16'h0000, 8,  1, 16'hA55A, 0, 8'h00};
    vecs[6] = '{1'b1, 1'b1, 4'hF, 8'h00, 16'h1234, 8,  0, 16'h0000, 1, 8'h34};
    vecs[7] = '{1'b0, 1'b1, 4'h1, 8'h77, 16'h0000, 8,  1, 16'hA577, 0, 8'h00};
    vecs[8] = '{1'b0, 1'b1, 4'h6, 8'h01, 16'h0000, 40, 1, 16'hA501, 0, 8'h00};
    vecs[9] = '{1'b0, 1'b1, 4'h2, 8'hFF, 16'h0000, 8,  1, 16'hA5FF, 0, 8'h00};

    // Reset held while the bus toggles: every output must stay zero.
    reset_n_i     = 1'b0;
    reg_rd_word_i = 16'hFFFF;
    busIdle();
    seen = '0;
    tick(1);
    for (int n = 0; n < 8; n++) begin
      bus_cs_n_i    = n[0];
      bus_rd_nwr_i  = n[1];
      bus_bytesel_i = 1'b1;
      bus_reg_num_i = 4'(n + 3);
      bus_data_i    = 8'(n * 37 + 1);
      tick(1);
      seen = seen | allOutputs();
    end
    checkOutput("reset_hold_outputs", seen, 32'h0);
    busIdle();
    reset_n_i = 1'b1;
    base = wrTotal + rdTotal;
    seen = '0;
    for (int n = 0; n < 10; n++) begin
      tick(1);
      seen = seen | {31'h0, bus_active_o};
    end
    checkOutput("reset_release_strobes", 32'(wrTotal + rdTotal - base), 32'h0);
    checkOutput("reset_release_active", seen, 32'h0);

    // Table of complete accesses.
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      applyStimulus(v, wrCount, wrEdge, wrWord, wrNum, rdCount, rdEdge,
                    dataEnd, activeEnd, activeClear);
      checkOutput($sformatf("v%0d_wr_count", i), 32'(wrCount), 32'(v.expWr));
      if (v.expWr != 0) begin
        checkRange($sformatf("v%0d_wr_edge", i), wrEdge, SS + SC, SS + SC + 1);
        checkOutput($sformatf("v%0d_wr_word", i), {16'h0, wrWord}, {16'h0, v.expWord});
        checkOutput($sformatf("v%0d_wr_num", i), {28'h0, wrNum}, {28'h0, v.rnum});
      end
      checkOutput($sformatf("v%0d_rd_count", i), 32'(rdCount), 32'(v.expRd));
      if (v.rd) begin
        checkOutput($sformatf("v%0d_rd_edge", i), 32'(rdEdge), 32'(SS));
        checkOutput($sformatf("v%0d_rd_data", i), {24'h0, dataEnd}, {24'h0, v.expData});
      end
      checkOutput($sformatf("v%0d_active_end", i), {31'h0, activeEnd}, 32'h1);
      checkOutput($sformatf("v%0d_active_clear", i), 32'(activeClear), 32'(SS));
    end

    // Select glitch: synced low for fewer clocks than settle needs, so no capture.
    base = wrTotal + rdTotal;
    seen = '0;
    bus_rd_nwr_i  = 1'b0;
    bus_bytesel_i = 1'b0;
    bus_reg_num_i = 4'hC;
    bus_data_i    = 8'h99;
    bus_cs_n_i    = 1'b0;
    tick(2);
    bus_cs_n_i = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick(1);
      seen = seen | {31'h0, bus_active_o};
    end
    busIdle();
    checkOutput("glitch_strobes", 32'(wrTotal + rdTotal - base), 32'h0);
    checkOutput("glitch_active", seen, 32'h0);
    checkOutput("glitch_reg_num", {28'h0, reg_num_o}, 32'h2);
    v = '{1'b0, 1'b1, 4'h4, 8'h3C, 16'h0000, 8, 1, 16'hA53C, 0, 8'h00};
    applyStimulus(v, wrCount, wrEdge, wrWord, wrNum, rdCount, rdEdge,
                  dataEnd, activeEnd, activeClear);
    checkOutput("post_glitch_wr_count", 32'(wrCount), 32'h1);
    checkOutput("post_glitch_wr_word", {16'h0, wrWord}, 32'h0000A53C);

    // Read data follows the register file during an access.
    base = rdTotal;
    reg_rd_word_i = 16'hBEEF;
    bus_rd_nwr_i  = 1'b1;
    bus_bytesel_i = 1'b1;
    bus_reg_num_i = 4'h3;
    bus_cs_n_i    = 1'b0;
    tick(7);
    checkOutput("track_before", {24'h0, bus_data_o}, 32'hEF);
    reg_rd_word_i = 16'hCAFE;
    tick(1);
    checkOutput("track_after", {24'h0, bus_data_o}, 32'hFE);
    busIdle();
    tick(6);
    checkOutput("track_rd_strobes", 32'(rdTotal - base), 32'h1);

    // Reset while settling: access dropped, no strobe afterwards.
    base = wrTotal + rdTotal;
    bus_rd_nwr_i  = 1'b0;
    bus_bytesel_i = 1'b1;
    bus_reg_num_i = 4'h7;
    bus_data_i    = 8'h11;
    bus_cs_n_i    = 1'b0;
    tick(4);
    reset_n_i = 1'b0;
    #1;
    checkOutput("rst_settle_outputs", allOutputs(), 32'h0);
    busIdle();
    tick(3);
    reset_n_i = 1'b1;
    tick(10);
    checkOutput("rst_settle_strobes", 32'(wrTotal + rdTotal - base), 32'h0);

    // Reset during a read hold: outputs clear, no read strobe on release.
    reg_rd_word_i = 16'hBEEF;
    bus_rd_nwr_i  = 1'b1;
    bus_bytesel_i = 1'b1;
    bus_reg_num_i = 4'h3;
    bus_cs_n_i    = 1'b0;
    tick(8);
    checkOutput("rst_read_pre_active", {31'h0, bus_active_o}, 32'h1);
    checkOutput("rst_read_pre_data", {24'h0, bus_data_o}, 32'hEF);
    base = rdTotal;
    reset_n_i = 1'b0;
    #1;
    checkOutput("rst_read_outputs", allOutputs(), 32'h0);
    busIdle();
    tick(3);
    reset_n_i = 1'b1;
    tick(10);
    checkOutput("rst_read_strobes", 32'(rdTotal - base), 32'h0);

    // The even-byte holding register also clears on reset.
    v = '{1'b0, 1'b1, 4'h0, 8'h42, 16'h0000, 8, 1, 16'h0042, 0, 8'h00};
    applyStimulus(v, wrCount, wrEdge, wrWord, wrNum, rdCount, rdEdge,
                  dataEnd, activeEnd, activeClear);
    checkOutput("hold_reset_wr_count", 32'(wrCount), 32'h1);
    checkOutput("hold_reset_wr_word", {16'h0, wrWord}, 32'h00000042);

    checkOutput("strobe_overlap", 32'(overlapCount), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
